// File: rtl/collision_event_scheduler_pkg.sv
// Shared types for the collision event scheduler.
//   event_code_t  : event type presented to the game controller
//   sched_state_t : scheduler state
//   NUM_BUBBLES_DEFAULT : default bubble object count
package game_pkg;

    typedef enum logic [1:0] {
        NONE       = 2'd0,
        CHAR_HIT   = 2'd1,
        BUBBLE_POP = 2'd2,
        ARROW_TOP  = 2'd3
    } event_code_t;

    typedef enum logic {
        COLLECT  = 1'b0,
        DISPATCH = 1'b1
    } sched_state_t;

    localparam int NUM_BUBBLES_DEFAULT = 4;

endpackage

// File: rtl/collision_event_scheduler_if.sv
// Event handshake between the scheduler and the game controller.
//   eventValid  : an event is presented
//   eventReady  : controller accepts the current event
//   eventCode   : event type
//   eventBubble : bubble index for CHAR_HIT / BUBBLE_POP, 0 otherwise
// master = scheduler side, slave = game controller side.
interface collision_event_scheduler_if #(
    parameter int BIDX_W = 2
);
    logic                     eventValid;
    logic                     eventReady;
    game_pkg::event_code_t    eventCode;
    logic [BIDX_W-1:0]        eventBubble;

    modport master (
        output eventValid,
        output eventCode,
        output eventBubble,
        input  eventReady
    );

    modport slave (
        input  eventValid,
        input  eventCode,
        input  eventBubble,
        output eventReady
    );
endinterface

// File: rtl/collision_event_scheduler_encoder.sv
// Lowest-set-bit encoder.
//   hits  : input hit vector (N bits)
//   found : at least one bit of hits is set
//   index : position of the lowest set bit (0 when none set)
module lowest_index_encoder #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     hits,
    output logic             found,
    output logic [IDX_W-1:0] index
);
    always_comb begin
        found = 1'b0;
        index = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (hits[i]) begin
                found = 1'b1;
                index = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/collision_event_scheduler.sv
// Collision event scheduler.
// Accumulates single-pixel collision pulses over a video frame, snapshots
// them on startOfFrame, arbitrates down to at most one game event and hands
// it to the game controller over a valid/ready handshake. Also holds the
// character border-block levels for the whole next frame.
//   clk, reset      : pixel clock, synchronous active-high reset
//   startOfFrame    : one-cycle frame boundary pulse
//   charCrashLeft/Right, arrowHitTop : border collision pulses
//   bubbleHitChar, arrowHitBubble    : per-bubble collision pulses
//   evt             : event handshake (master side)
//   charBlockLeft/Right : movement block levels for the current frame
//   overrun         : pulse, an undelivered event was replaced by a new frame
//
// state    | meaning
// ---------+-----------------------------------------------------
// COLLECT  | no event pending, accumulating hits
// DISPATCH | one event presented on evt, waiting for eventReady
module collision_event_scheduler
    import game_pkg::*;
#(
    parameter int NUM_BUBBLES = NUM_BUBBLES_DEFAULT,
    parameter int BIDX_W      = (NUM_BUBBLES > 1) ? $clog2(NUM_BUBBLES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startOfFrame,
    input  logic                   charCrashLeft,
    input  logic                   charCrashRight,
    input  logic                   arrowHitTop,
    input  logic [NUM_BUBBLES-1:0] bubbleHitChar,
    input  logic [NUM_BUBBLES-1:0] arrowHitBubble,
    collision_event_scheduler_if.master evt,
    output logic                   charBlockLeft,
    output logic                   charBlockRight,
    output logic                   overrun
);
    sched_state_t           state;
    logic                   colLeft, colRight, colTop;
    logic [NUM_BUBBLES-1:0] colBubbleChar, colArrowBubble;

    logic                   eventValidQ;
    event_code_t            eventCodeQ;
    logic [BIDX_W-1:0]      eventBubbleQ;

    // Snapshot view: hits landing in the startOfFrame cycle still belong
    // to the frame that is ending.
    logic                   snapLeft, snapRight, snapTop;
    logic [NUM_BUBBLES-1:0] snapBubbleChar, snapArrowBubble;

    assign snapLeft        = colLeft | charCrashLeft;
    assign snapRight       = colRight | charCrashRight;
    assign snapTop         = colTop | arrowHitTop;
    assign snapBubbleChar  = colBubbleChar | bubbleHitChar;
    assign snapArrowBubble = colArrowBubble | arrowHitBubble;

    logic              charFound, popFound;
    logic [BIDX_W-1:0] charIdx, popIdx;

    lowest_index_encoder #(.N(NUM_BUBBLES), .IDX_W(BIDX_W)) charEnc (
        .hits  (snapBubbleChar),
        .found (charFound),
        .index (charIdx)
    );

    lowest_index_encoder #(.N(NUM_BUBBLES), .IDX_W(BIDX_W)) popEnc (
        .hits  (snapArrowBubble),
        .found (popFound),
        .index (popIdx)
    );

    // Arbitration: a lost life wipes the frame, one pop per arrow, and a
    // pop suppresses the arrow reaching the top.
    event_code_t       nextCode;
    logic [BIDX_W-1:0] nextIdx;

    always_comb begin
        nextCode = NONE;
        nextIdx  = '0;
        if (charFound) begin
            nextCode = CHAR_HIT;
            nextIdx  = charIdx;
        end else if (popFound) begin
            nextCode = BUBBLE_POP;
            nextIdx  = popIdx;
        end else if (snapTop) begin
            nextCode = ARROW_TOP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= COLLECT;
            colLeft        <= 1'b0;
            colRight       <= 1'b0;
            colTop         <= 1'b0;
            colBubbleChar  <= '0;
            colArrowBubble <= '0;
            eventValidQ    <= 1'b0;
            eventCodeQ     <= NONE;
            eventBubbleQ   <= '0;
            charBlockLeft  <= 1'b0;
            charBlockRight <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (startOfFrame) begin
                colLeft        <= 1'b0;
                colRight       <= 1'b0;
                colTop         <= 1'b0;
                colBubbleChar  <= '0;
                colArrowBubble <= '0;
                charBlockLeft  <= snapLeft;
                charBlockRight <= snapRight;
                // Ready in the boundary cycle still counts as a delivery.
                overrun        <= (state == DISPATCH) && !evt.eventReady;
                eventCodeQ     <= nextCode;
                eventBubbleQ   <= nextIdx;
                if (nextCode != NONE) begin
                    state       <= DISPATCH;
                    eventValidQ <= 1'b1;
                end else begin
                    state       <= COLLECT;
                    eventValidQ <= 1'b0;
                end
            end else begin
                colLeft        <= snapLeft;
                colRight       <= snapRight;
                colTop         <= snapTop;
                colBubbleChar  <= snapBubbleChar;
                colArrowBubble <= snapArrowBubble;
                if (state == DISPATCH && evt.eventReady) begin
                    state        <= COLLECT;
                    eventValidQ  <= 1'b0;
                    eventCodeQ   <= NONE;
                    eventBubbleQ <= '0;
                end
            end
        end
    end

    assign evt.eventValid  = eventValidQ;
    assign evt.eventCode   = eventCodeQ;
    assign evt.eventBubble = eventBubbleQ;
endmodule

// File: tb/tb_collision_event_scheduler.sv
module tb_collision_event_scheduler;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          startOfFrame;
    logic          charCrashLeft;
    logic          charCrashRight;
    logic          arrowHitTop;
    logic [NB-1:0] bubbleHitChar;
    logic [NB-1:0] arrowHitBubble;
    logic          charBlockLeft;
    logic          charBlockRight;
    logic          overrun;

    int vectors = 0;
    int miscompares = 0;

    collision_event_scheduler_if #(.BIDX_W(2)) evtIf ();

    collision_event_scheduler #(.NUM_BUBBLES(NB), .BIDX_W(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .charCrashLeft  (charCrashLeft),
        .charCrashRight (charCrashRight),
        .arrowHitTop    (arrowHitTop),
        .bubbleHitChar  (bubbleHitChar),
        .arrowHitBubble (arrowHitBubble),
        .evt            (evtIf),
        .charBlockLeft  (charBlockLeft),
        .charBlockRight (charBlockRight),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: a frame's worth of hits as plain sets, plus the
    // single event the controller is expected to see.
    bit mBubbleChar[NB];
    bit mArrowBubble[NB];
    bit mLeft, mRight, mTop;
    bit expValid, expBlockL, expBlockR, expOverrun;
    int expCode, expIdx;

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            mBubbleChar[i]  = 0;
            mArrowBubble[i] = 0;
        end
        mLeft = 0; mRight = 0; mTop = 0;
        expValid = 0; expBlockL = 0; expBlockR = 0; expOverrun = 0;
        expCode = 0; expIdx = 0;
    endtask

    task automatic model_step();
        int charI, popI;
        for (int i = 0; i < NB; i++) begin
            if (bubbleHitChar[i])  mBubbleChar[i]  = 1;
            if (arrowHitBubble[i]) mArrowBubble[i] = 1;
        end
        if (charCrashLeft)  mLeft  = 1;
        if (charCrashRight) mRight = 1;
        if (arrowHitTop)    mTop   = 1;
        expOverrun = 0;
        if (startOfFrame) begin
            expOverrun = expValid && !evtIf.eventReady;
            charI = -1;
            popI  = -1;
            for (int i = NB - 1; i >= 0; i--) begin
                if (mBubbleChar[i])  charI = i;
                if (mArrowBubble[i]) popI  = i;
            end
            if (charI >= 0)      begin expCode = 1; expIdx = charI; end
            else if (popI >= 0)  begin expCode = 2; expIdx = popI; end
            else if (mTop)       begin expCode = 3; expIdx = 0; end
            else                 begin expCode = 0; expIdx = 0; end
            expValid  = (expCode != 0);
            expBlockL = mLeft;
            expBlockR = mRight;
            for (int i = 0; i < NB; i++) begin
                mBubbleChar[i]  = 0;
                mArrowBubble[i] = 0;
            end
            mLeft = 0; mRight = 0; mTop = 0;
        end else if (expValid && evtIf.eventReady) begin
            expValid = 0; expCode = 0; expIdx = 0;
        end
    endtask

    task automatic clear_inputs();
        startOfFrame   = 0;
        charCrashLeft  = 0;
        charCrashRight = 0;
        arrowHitTop    = 0;
        bubbleHitChar  = '0;
        arrowHitBubble = '0;
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame_boundary();
        startOfFrame = 1;
        tick();
        startOfFrame = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        evtIf.eventReady = 0;
        reset = 1;
        tick(2);
        reset = 0;
        vectors++;
        if (evtIf.eventValid !== 1'b0 || evtIf.eventCode !== 2'd0 || evtIf.eventBubble !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_event: valid=%b code=%0d bubble=%0d, required 0/0/0",
                     evtIf.eventValid, evtIf.eventCode, evtIf.eventBubble);
        end
        vectors++;
        if (charBlockLeft !== 1'b0 || charBlockRight !== 1'b0 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_levels: blockL=%b blockR=%b overrun=%b, required 0/0/0",
                     charBlockLeft, charBlockRight, overrun);
        end
    endtask

    task automatic test_single_pop();
        tick(3);
        arrowHitBubble = 4'b0100;
        tick();
        arrowHitBubble = '0;
        tick(2);
        evtIf.eventReady = 1;
        frame_boundary();
        vectors++;
        if (evtIf.eventValid !== 1'b1 || evtIf.eventCode !== 2'd2 || evtIf.eventBubble !== 2'd2) begin
            miscompares++;
            $display("FAIL single_pop_t1: valid=%b code=%0d bubble=%0d, required 1/2/2",
                     evtIf.eventValid, evtIf.eventCode, evtIf.eventBubble);
        end
        tick();
        vectors++;
        if (evtIf.eventValid !== 1'b0 || evtIf.eventCode !== 2'd0) begin
            miscompares++;
            $display("FAIL single_pop_t2: valid=%b code=%0d, required 0/0",
                     evtIf.eventValid, evtIf.eventCode);
        end
        evtIf.eventReady = 0;
    endtask

    task automatic test_pop_priority();
        tick(2);
        arrowHitBubble = 4'b1010;
        arrowHitTop    = 1;
        tick();
        clear_inputs();
        tick(2);
        frame_boundary();
        vectors++;
        if (evtIf.eventValid !== 1'b1 || evtIf.eventCode !== 2'd2 || evtIf.eventBubble !== 2'd1) begin
            miscompares++;
            $display("FAIL pop_priority: valid=%b code=%0d bubble=%0d, required 1/2/1",
                     evtIf.eventValid, evtIf.eventCode, evtIf.eventBubble);
        end
        evtIf.eventReady = 1;
        tick();
        evtIf.eventReady = 0;
        tick(3);
        frame_boundary();
        vectors++;
        if (evtIf.eventValid !== 1'b0 || evtIf.eventCode !== 2'd0) begin
            miscompares++;
            $display("FAIL pop_no_arrow_top: valid=%b code=%0d, required 0/0",
                     evtIf.eventValid, evtIf.eventCode);
        end
    endtask

    task automatic test_char_hit();
        tick(2);
        bubbleHitChar  = 4'b1000;
        arrowHitBubble = 4'b0001;
        charCrashLeft  = 1;
        tick();
        clear_inputs();
        tick(2);
        frame_boundary();
        vectors++;
        if (evtIf.eventValid !== 1'b1 || evtIf.eventCode !== 2'd1 || evtIf.eventBubble !== 2'd3
            || charBlockLeft !== 1'b1) begin
            miscompares++;
            $display("FAIL char_hit: valid=%b code=%0d bubble=%0d blockL=%b, required 1/1/3/1",
                     evtIf.eventValid, evtIf.eventCode, evtIf.eventBubble, charBlockLeft);
        end
        evtIf.eventReady = 1;
        tick();
        evtIf.eventReady = 0;
        tick(8);
        vectors++;
        if (charBlockLeft !== 1'b1 || evtIf.eventValid !== 1'b0) begin
            miscompares++;
            $display("FAIL char_block_hold: blockL=%b valid=%b, required 1/0",
                     charBlockLeft, evtIf.eventValid);
        end
        frame_boundary();
        vectors++;
        if (charBlockLeft !== 1'b0 || evtIf.eventValid !== 1'b0) begin
            miscompares++;
            $display("FAIL char_block_release: blockL=%b valid=%b, required 0/0",
                     charBlockLeft, evtIf.eventValid);
        end
    endtask

    task automatic test_overrun();
        arrowHitTop = 1;
        tick();
        arrowHitTop = 0;
        frame_boundary();
        vectors++;
        if (evtIf.eventValid !== 1'b1 || evtIf.eventCode !== 2'd3 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_first: valid=%b code=%0d overrun=%b, required 1/3/0",
                     evtIf.eventValid, evtIf.eventCode, overrun);
        end
        tick(3);
        arrowHitBubble = 4'b0010;
        tick();
        arrowHitBubble = '0;
        tick(2);
        frame_boundary();
        vectors++;
        if (overrun !== 1'b1 || evtIf.eventValid !== 1'b1 || evtIf.eventCode !== 2'd2
            || evtIf.eventBubble !== 2'd1) begin
            miscompares++;
            $display("FAIL overrun_pulse: overrun=%b valid=%b code=%0d bubble=%0d, required 1/1/2/1",
                     overrun, evtIf.eventValid, evtIf.eventCode, evtIf.eventBubble);
        end
        tick();
        vectors++;
        if (overrun !== 1'b0 || evtIf.eventValid !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_one_cycle: overrun=%b valid=%b, required 0/1",
                     overrun, evtIf.eventValid);
        end
        // Ready coinciding with the boundary delivers the old event.
        arrowHitTop = 1;
        tick();
        arrowHitTop = 0;
        evtIf.eventReady = 1;
        frame_boundary();
        vectors++;
        if (overrun !== 1'b0 || evtIf.eventValid !== 1'b1 || evtIf.eventCode !== 2'd3) begin
            miscompares++;
            $display("FAIL overrun_ready_same: overrun=%b valid=%b code=%0d, required 0/1/3",
                     overrun, evtIf.eventValid, evtIf.eventCode);
        end
        tick();
        evtIf.eventReady = 0;
    endtask

    task automatic test_coincident_right();
        tick(2);
        charCrashRight = 1;
        frame_boundary();
        charCrashRight = 0;
        vectors++;
        if (charBlockRight !== 1'b1 || evtIf.eventValid !== 1'b0) begin
            miscompares++;
            $display("FAIL coincident_right: blockR=%b valid=%b, required 1/0",
                     charBlockRight, evtIf.eventValid);
        end
        tick(5);
        frame_boundary();
        vectors++;
        if (charBlockRight !== 1'b0) begin
            miscompares++;
            $display("FAIL coincident_right_clear: blockR=%b, required 0", charBlockRight);
        end
    endtask

    task automatic test_reset_mid_dispatch();
        charCrashLeft = 1;
        arrowHitTop   = 1;
        tick();
        clear_inputs();
        frame_boundary();
        vectors++;
        if (evtIf.eventValid !== 1'b1 || charBlockLeft !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_setup: valid=%b blockL=%b, required 1/1",
                     evtIf.eventValid, charBlockLeft);
        end
        arrowHitBubble = 4'b0001;
        reset = 1;
        tick();
        reset = 0;
        arrowHitBubble = '0;
        vectors++;
        if (evtIf.eventValid !== 1'b0 || evtIf.eventCode !== 2'd0 || evtIf.eventBubble !== 2'd0
            || charBlockLeft !== 1'b0 || charBlockRight !== 1'b0 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: valid=%b code=%0d bubble=%0d blockL=%b blockR=%b overrun=%b, required all 0",
                     evtIf.eventValid, evtIf.eventCode, evtIf.eventBubble,
                     charBlockLeft, charBlockRight, overrun);
        end
        tick(4);
        frame_boundary();
        vectors++;
        if (evtIf.eventValid !== 1'b0 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_empty_frame: valid=%b overrun=%b, required 0/0",
                     evtIf.eventValid, overrun);
        end
    endtask

    task automatic test_random();
        int countdown;
        clear_inputs();
        evtIf.eventReady = 0;
        reset = 1;
        tick();
        reset = 0;
        model_reset();
        countdown = $urandom_range(4, 16);
        for (int c = 0; c < 3000; c++) begin
            startOfFrame   = (countdown == 0);
            charCrashLeft  = ($urandom_range(0, 19) == 0);
            charCrashRight = ($urandom_range(0, 19) == 0);
            arrowHitTop    = ($urandom_range(0, 14) == 0);
            for (int i = 0; i < NB; i++) begin
                bubbleHitChar[i]  = ($urandom_range(0, 59) == 0);
                arrowHitBubble[i] = ($urandom_range(0, 29) == 0);
            end
            evtIf.eventReady = ($urandom_range(0, 3) == 0);
            countdown = (countdown == 0) ? $urandom_range(4, 16) : countdown - 1;
            tick();
            model_step();
            vectors++;
            if (evtIf.eventValid !== expValid || evtIf.eventCode !== 2'(expCode)
                || evtIf.eventBubble !== 2'(expIdx)) begin
                miscompares++;
                $display("FAIL random_event cycle %0d: valid=%b code=%0d bubble=%0d, required %b/%0d/%0d",
                         c, evtIf.eventValid, evtIf.eventCode, evtIf.eventBubble,
                         expValid, expCode, expIdx);
            end
            vectors++;
            if (charBlockLeft !== expBlockL || charBlockRight !== expBlockR || overrun !== expOverrun) begin
                miscompares++;
                $display("FAIL random_levels cycle %0d: blockL=%b blockR=%b overrun=%b, required %b/%b/%b",
                         c, charBlockLeft, charBlockRight, overrun,
                         expBlockL, expBlockR, expOverrun);
            end
        end
        clear_inputs();
        evtIf.eventReady = 0;
    endtask

    initial begin
        reset = 1;
        evtIf.eventReady = 0;
        clear_inputs();
        test_reset();
        test_single_pop();
        test_pop_priority();
        test_char_hit();
        test_overrun();
        test_coincident_right();
        test_reset_mid_dispatch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/collision_event_scheduler.md
Name: collision_event_scheduler

Overview:
- Sits between the per-pixel collision detector and the game-state logic (character, arrow, bubble movers).
- Collision flags from the detector are single-pixel pulses, asserted only while overlapping objects are being drawn. This block accumulates them over one video frame.
- On each frame boundary it snapshots the accumulated flags, applies game arbitration rules, and hands the surviving events one at a time to the game controller over a valid/ready handshake.
- It also holds the character border-block levels for the whole next frame.

Parameters:
- NUM_BUBBLES, 4, number of bubble objects; width of the per-bubble hit vectors.
- BIDX_W, $clog2(NUM_BUBBLES) (minimum 1), width of the bubble index output.

Ports:
- clk  in  1  system clock (pixel clock domain).
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse marking the frame boundary.
- charCrashLeft  in  1  pixel pulse: character touches the left border.
- charCrashRight  in  1  pixel pulse: character touches the right border.
- arrowHitTop  in  1  pixel pulse: arrow touches the top border.
- bubbleHitChar  in  NUM_BUBBLES  pixel pulses: bubble i overlaps the character.
- arrowHitBubble  in  NUM_BUBBLES  pixel pulses: arrow overlaps bubble i.
- eventReady  in  1  game controller accepts the current event.
- eventValid  out  1  an event is presented.
- eventCode  out  2  event type: 0 NONE, 1 CHAR_HIT, 2 BUBBLE_POP, 3 ARROW_TOP.
- eventBubble  out  BIDX_W  bubble index for CHAR_HIT and BUBBLE_POP; 0 otherwise.
- charBlockLeft  out  1  level, held for one frame: character may not move left.
- charBlockRight  out  1  level, held for one frame: character may not move right.
- overrun  out  1  one-cycle pulse: a frame boundary arrived while events were still pending.

Behaviour:
Reset:
- State COLLECT; collect and pending registers cleared.
- All outputs 0; eventCode = NONE.
- A reset mid-dispatch discards everything, with no overrun pulse.

Collect registers:
- Sticky OR of every input pulse, in every state.
- On the cycle after startOfFrame they are cleared.
- A hit arriving in the same cycle as startOfFrame belongs to the ending frame and is included in the snapshot.

Snapshot (startOfFrame at cycle t; results visible at t+1):
- charBlockLeft/Right take the collected left/right flags and hold them until the next snapshot.
- Pending events are built by these arbitration rules:
  - Any bubbleHitChar bit set: pending = {CHAR_HIT, lowest set index} only. All other events are discarded (life lost).
  - Otherwise, any arrowHitBubble bit set: BUBBLE_POP with the lowest set index. Other arrowHitBubble bits are dropped (one pop per arrow). ARROW_TOP is suppressed.
  - Otherwise, arrowHitTop set: ARROW_TOP.
- At most one event is pending per frame; the pending set is a 1-entry register holding code and index.
- If the pending set is empty, stay in COLLECT.
- If the pending set is non-empty, go to DISPATCH with eventValid = 1 at t+1.

DISPATCH:
- eventValid, eventCode and eventBubble are held stable until eventValid && eventReady.
- On acceptance: at the next cycle eventValid = 0, code = NONE, index = 0, state = COLLECT.
- eventReady is ignored while eventValid = 0.

Overrun:
- startOfFrame while in DISPATCH with the event not yet accepted: the old event is dropped and overrun pulses at t+1.
- The new snapshot is loaded at t+1 exactly as normal.
- If eventReady is high in that same cycle t, the old event counts as accepted and there is no overrun.

Latency:
- Pixel hit to eventValid: up to one frame plus 1 cycle.
- Acceptance to eventValid deassertion: 1 cycle.

Decomposition:
- Package game_pkg holds the event_code_t enum (NONE, CHAR_HIT, BUBBLE_POP, ARROW_TOP), the state enum (COLLECT, DISPATCH) and the NUM_BUBBLES default.
- Sub-module lowest_index_encoder (parameter N) returns {found, index} for a hit vector. It is instantiated twice: once for bubbleHitChar and once for arrowHitBubble.

Test Plan:
- arrowHitBubble[2] pulses mid-frame, then startOfFrame, eventReady = 1 -> cycle t+1: eventValid = 1, code 2, bubble 2; cycle t+2: eventValid = 0.
- arrowHitBubble = 4'b1010 and arrowHitTop in the same frame, then startOfFrame -> exactly one event: code 2, bubble 1; ARROW_TOP never presented.
- bubbleHitChar[3] plus arrowHitBubble[0] plus charCrashLeft, then startOfFrame -> single event: code 1, bubble 3; charBlockLeft = 1 for the next full frame, then 0 after a clean frame.
- arrowHitTop, startOfFrame, eventReady held 0 until a second startOfFrame with arrowHitBubble[1] collected -> overrun pulses at t+1; event becomes code 2, bubble 1.
- charCrashRight coincident with startOfFrame -> charBlockRight = 1 from t+1; the collect register is clear at t+1, so a frame with no further hits gives charBlockRight = 0 after the following snapshot.
- Reset asserted during DISPATCH with eventValid = 1 -> next cycle: all outputs 0, no overrun; a subsequent empty frame produces no event.
